// File: rtl/scancode_generator_if.sv
// Key-event handshake between an event source and the scan-code generator.
// The source owns the event fields and valid; the generator owns ready.
interface scancode_generator_if;
    logic [7:0] keycode;
    logic       ext;
    logic       make;
    logic       keycode_valid;
    logic       keycode_ready;

    modport master (
        output keycode,
        output ext,
        output make,
        output keycode_valid,
        input  keycode_ready
    );

    modport slave (
        input  keycode,
        input  ext,
        input  make,
        input  keycode_valid,
        output keycode_ready
    );
endinterface

// File: rtl/scancode_generator.sv
// Serialises decoded key events into PS/2 Set-2 scan bytes ([E0] [F0] code),
// one ps2_key_en strobe per byte with a fixed idle gap between strobes.
module scancode_generator #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 9
) (
    input  logic                 clk,
    input  logic                 reset_n,
    scancode_generator_if.slave  ev,
    output logic [7:0]           ps2_key_data,
    output logic                 ps2_key_en,
    output logic                 busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StSendE0, StSendF0, StSendCode, StGap} state_e;

    // FIFO entry layout: {ext, make, keycode}
    logic [9:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    state_e          state_q, state_d;
    state_e          sent_q, sent_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [9:0]      hold_q, hold_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;

    logic            push, pop, start, empty;
    logic [9:0]      head;

    assign ev.keycode_ready = (count_q != CntW'(DEPTH));
    assign empty            = (count_q == '0);
    assign push             = ev.keycode_valid && ev.keycode_ready;
    assign head             = mem_q[rd_ptr_q];

    assign ps2_key_data = data_q;
    assign ps2_key_en   = en_q;
    assign busy         = (state_q != StIdle) || !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ev.ext, ev.make, ev.keycode};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        gap_d   = gap_q;
        hold_d  = hold_q;
        data_d  = data_q;
        en_d    = 1'b0;
        pop     = 1'b0;
        start   = 1'b0;

        unique case (state_q)
            StIdle: start = !empty;
            StSendE0, StSendF0, StSendCode: begin
                sent_d  = state_q;
                gap_d   = GapW'(GAP_CYCLES - 1);
                state_d = StGap;
            end
            StGap: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GapW'(1);
                end else begin
                    unique case (sent_q)
                        StSendE0: begin
                            en_d = 1'b1;
                            if (hold_q[8]) begin
                                data_d  = hold_q[7:0];
                                state_d = StSendCode;
                            end else begin
                                data_d  = 8'hF0;
                                state_d = StSendF0;
                            end
                        end
                        StSendF0: begin
                            en_d    = 1'b1;
                            data_d  = hold_q[7:0];
                            state_d = StSendCode;
                        end
                        default: begin
                            // Chain straight into the next event to keep the byte period exact.
                            state_d = StIdle;
                            start   = !empty;
                        end
                    endcase
                end
            end
            default: state_d = StIdle;
        endcase

        if (start) begin
            pop    = 1'b1;
            hold_d = head;
            en_d   = 1'b1;
            if (head[9]) begin
                data_d  = 8'hE0;
                state_d = StSendE0;
            end else if (!head[8]) begin
                data_d  = 8'hF0;
                state_d = StSendF0;
            end else begin
                data_d  = head[7:0];
                state_d = StSendCode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= StIdle;
            sent_q   <= StIdle;
            gap_q    <= '0;
            hold_q   <= '0;
            data_q   <= 8'h00;
            en_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            sent_q   <= sent_d;
            gap_q    <= gap_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            en_q     <= en_d;
        end
    end

endmodule

// File: tb/tb_scancode_generator.sv
// Directed bench: default build (GAP 9) plus a GAP 1 build, both with DEPTH 4.
module tb_scancode_generator;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    scancode_generator_if if0 ();
    scancode_generator_if if1 ();

    logic [7:0] data0, data1;
    logic       en0, en1, busy0, busy1;

    scancode_generator #(.DEPTH(4), .GAP_CYCLES(9)) u_dut0 (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev           (if0),
        .ps2_key_data (data0),
        .ps2_key_en   (en0),
        .busy         (busy0)
    );

    scancode_generator #(.DEPTH(4), .GAP_CYCLES(1)) u_dut1 (
        .clk          (clk),
        .reset_n      (reset_n),
        .ev           (if1),
        .ps2_key_data (data1),
        .ps2_key_en   (en1),
        .busy         (busy1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int fall0  = 0;
    logic busy0_prev = 1'b0;
    logic [7:0] sb0_q[$];
    int         sc0_q[$];
    logic [7:0] sb1_q[$];
    int         sc1_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (en0) begin
            sb0_q.push_back(data0);
            sc0_q.push_back(cyc);
        end
        if (en1) begin
            sb1_q.push_back(data1);
            sc1_q.push_back(cyc);
        end
        if (busy0_prev && !busy0) fall0 <= cyc;
        busy0_prev <= busy0;
    end

    typedef struct {
        logic       ext;
        logic       make;
        logic [7:0] code;
        int         n;
        logic [7:0] b0, b1, b2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input int sel);
        return (sel == 0) ? if0.keycode_ready : if1.keycode_ready;
    endfunction

    task automatic drive(input int sel, input logic v, input logic e, input logic m,
                         input logic [7:0] c);
        if (sel == 0) begin
            if0.keycode_valid = v; if0.ext = e; if0.make = m; if0.keycode = c;
        end else begin
            if1.keycode_valid = v; if1.ext = e; if1.make = m; if1.keycode = c;
        end
    endtask

    // acc = cycle count at the negedge just before the accepting edge
    task automatic send(input int sel, input logic e, input logic m, input logic [7:0] c,
                        output int acc);
        int n = 0;
        @(negedge clk);
        drive(sel, 1'b1, e, m, c);
        while (!ready_of(sel) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", ready_of(sel), 1'b1);
        acc = cyc;
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel == 0) ? busy0 : busy1) && n < 1000);
        check("idle_timeout", (sel == 0) ? busy0 : busy1, 1'b0);
        @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input int sel, input logic [7:0] exp[$],
                                input int period);
        logic [7:0] b[$];
        int         c[$];
        if (sel == 0) begin b = sb0_q; c = sc0_q; end
        else          begin b = sb1_q; c = sc1_q; end
        check({tag, "_count"}, b.size(), exp.size());
        if (b.size() == exp.size()) begin
            for (int i = 0; i < exp.size(); i++) begin
                check($sformatf("%s_byte%0d", tag, i), b[i], exp[i]);
                if (i > 0) check($sformatf("%s_gap%0d", tag, i), c[i] - c[i-1], period);
            end
        end
    endtask

    task automatic clear_q();
        sb0_q.delete(); sc0_q.delete(); sb1_q.delete(); sc1_q.delete();
    endtask

    vec_t       vecs[6];
    logic [7:0] exp_q[$];
    int         acc;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'hAA, 1, 8'hAA, 8'h00, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'hBB, 2, 8'hF0, 8'hBB, 8'h00};
        vecs[2] = '{1'b1, 1'b1, 8'hCC, 2, 8'hE0, 8'hCC, 8'h00};
        vecs[3] = '{1'b1, 1'b0, 8'hDD, 3, 8'hE0, 8'hF0, 8'hDD};
        vecs[4] = '{1'b0, 1'b1, 8'hE0, 1, 8'hE0, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 1'b0, 8'hF0, 3, 8'hE0, 8'hF0, 8'hF0};

        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset state, and pushes during reset must be ignored
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b1, 8'h55);
        repeat (2) @(negedge clk);
        check("rst_en", en0, 1'b0);
        check("rst_data", data0, 8'h00);
        check("rst_busy", busy0, 1'b0);
        check("rst_ready", if0.keycode_ready, 1'b1);
        drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_busy", busy0, 1'b0);
        check("post_rst_strobes", sb0_q.size(), 0);

        // Table: one event at a time from idle
        foreach (vecs[k]) begin
            clear_q();
            send(0, vecs[k].ext, vecs[k].make, vecs[k].code, acc);
            wait_idle(0);
            exp_q.delete();
            exp_q.push_back(vecs[k].b0);
            if (vecs[k].n > 1) exp_q.push_back(vecs[k].b1);
            if (vecs[k].n > 2) exp_q.push_back(vecs[k].b2);
            check_stream($sformatf("vec%0d", k), 0, exp_q, 10);
            if (sc0_q.size() > 0) begin
                check($sformatf("vec%0d_latency", k), sc0_q[0] - acc, 2);
                check($sformatf("vec%0d_busy_fall", k), fall0 - sc0_q[sc0_q.size()-1], 10);
            end else begin
                check($sformatf("vec%0d_no_strobe", k), sc0_q.size(), 1);
            end
        end

        // Burst of 6 with valid held high: stall after 5 accepts (one popped, four queued)
        begin
            logic [9:0] bev[6];
            int k = 0, stall_at = -1, guard = 0;
            bev[0] = {2'b01, 8'h11}; bev[1] = {2'b00, 8'h22}; bev[2] = {2'b11, 8'h33};
            bev[3] = {2'b10, 8'h44}; bev[4] = {2'b01, 8'h55}; bev[5] = {2'b01, 8'h66};
            clear_q();
            while (k < 6 && guard < 400) begin
                @(negedge clk);
                guard++;
                drive(0, 1'b1, bev[k][9], bev[k][8], bev[k][7:0]);
                if (if0.keycode_ready) k++;
                else if (stall_at < 0) stall_at = k;
            end
            @(posedge clk);
            #1 drive(0, 1'b0, 1'b0, 1'b0, 8'h00);
            check("burst_accepted", k, 6);
            check("burst_stall_at", stall_at, 5);
            wait_idle(0);
            exp_q = '{8'h11, 8'hF0, 8'h22, 8'hE0, 8'h33, 8'hE0, 8'hF0, 8'h44, 8'h55, 8'h66};
            check_stream("burst", 0, exp_q, 10);
        end

        // Reset during the E0 strobe of an ext break
        begin
            int n = 0;
            clear_q();
            send(0, 1'b1, 1'b0, 8'hDD, acc);
            while (!en0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("midrst_saw_e0", data0, 8'hE0);
            #1 reset_n = 1'b0;
            #1;
            check("midrst_en_async", en0, 1'b0);
            check("midrst_busy", busy0, 1'b0);
            check("midrst_ready", if0.keycode_ready, 1'b1);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            clear_q();
            repeat (30) @(negedge clk);
            check("midrst_no_more", sb0_q.size(), 0);
            check("midrst_idle", busy0, 1'b0);
            send(0, 1'b0, 1'b1, 8'hAA, acc);
            wait_idle(0);
            exp_q = '{8'hAA};
            check_stream("after_rst", 0, exp_q, 10);
        end

        // GAP_CYCLES=1 build: break 12 on alternate clocks
        clear_q();
        send(1, 1'b0, 1'b0, 8'h12, acc);
        wait_idle(1);
        exp_q = '{8'hF0, 8'h12};
        check_stream("gap1_break", 1, exp_q, 2);
        if (sc1_q.size() > 0) check("gap1_latency", sc1_q[0] - acc, 2);

        // GAP 1 burst: push+pop at count 3 keeps ready high, so stall only after 7 accepts
        begin
            int k = 0, stall_at = -1, guard = 0;
            clear_q();
            while (k < 8 && guard < 400) begin
                @(negedge clk);
                guard++;
                drive(1, 1'b1, 1'b0, 1'b1, 8'h81 + 8'(k));
                if (if1.keycode_ready) k++;
                else if (stall_at < 0) stall_at = k;
            end
            @(posedge clk);
            #1 drive(1, 1'b0, 1'b0, 1'b0, 8'h00);
            check("gap1_burst_accepted", k, 8);
            check("gap1_stall_at", stall_at, 7);
            wait_idle(1);
            exp_q = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
            check_stream("gap1_burst", 1, exp_q, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
